// File: rtl/dispatch_queue_pkg.sv
// Shared types for the dispatch queue: opcode/funct3 enums, control and RVFI
// words, and the invalid control word shown when the queue is empty.
package dispatch_queue_pkg;

  typedef enum logic [6:0] {
    s_op_invalid = 7'b0000000,
    s_op_lui     = 7'b0110111,
    s_op_auipc   = 7'b0010111,
    s_op_jal     = 7'b1101111,
    s_op_jalr    = 7'b1100111,
    s_op_br      = 7'b1100011,
    s_op_load    = 7'b0000011,
    s_op_store   = 7'b0100011,
    s_op_imm     = 7'b0010011,
    s_op_reg     = 7'b0110011
  } rv32i_opcode;

  typedef enum logic [2:0] {
    f3_add  = 3'd0,
    f3_sll  = 3'd1,
    f3_slt  = 3'd2,
    f3_sltu = 3'd3,
    f3_xor  = 3'd4,
    f3_sr   = 3'd5,
    f3_or   = 3'd6,
    f3_and  = 3'd7
  } arith_funct3;

  typedef struct packed {
    rv32i_opcode opcode;
    arith_funct3 funct3;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } ctl_word;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } rvfi_word;

  localparam ctl_word CTL_INVALID = '{opcode: s_op_invalid, funct3: f3_add,
                                      rd: '0, rs1: '0, rs2: '0, imm: '0};

  // slt/sltu in either immediate or register form go to the compare stations
  function automatic logic is_cmp_op(ctl_word c);
    return ((c.opcode == s_op_imm) || (c.opcode == s_op_reg)) &&
           ((c.funct3 == f3_slt) || (c.funct3 == f3_sltu));
  endfunction

endpackage

// File: rtl/dispatch_queue_if.sv
// Decode-side and back-end-side signals of the dispatch queue.
interface dispatch_queue_if import dispatch_queue_pkg::*; #(
  parameter int N_ALU = 2,
  parameter int N_CMP = 2,
  parameter int CNT_W = 4
) ();
  logic             flush_ip;
  logic             ld_iq;
  ctl_word          ctl_i;
  rvfi_word         rvfi_i;
  logic             ack_o;
  logic [N_ALU-1:0] alu_empty;
  logic [N_CMP-1:0] cmp_empty;
  logic             resbr_empty;
  logic             lsq_empty;
  logic             rob_full;
  logic [N_ALU-1:0] alu_load;
  logic [N_CMP-1:0] cmp_load;
  logic             resbr_load;
  logic             lsq_load;
  logic             rob_load;
  logic             regfile_allocate;
  ctl_word          control_o;
  rvfi_word         rvfi_o;
  logic [CNT_W-1:0] count_o;
  logic [31:0]      stall_cnt_o;

  modport master (
    output flush_ip, ld_iq, ctl_i, rvfi_i, alu_empty, cmp_empty,
           resbr_empty, lsq_empty, rob_full,
    input  ack_o, alu_load, cmp_load, resbr_load, lsq_load, rob_load,
           regfile_allocate, control_o, rvfi_o, count_o, stall_cnt_o
  );

  modport slave (
    input  flush_ip, ld_iq, ctl_i, rvfi_i, alu_empty, cmp_empty,
           resbr_empty, lsq_empty, rob_full,
    output ack_o, alu_load, cmp_load, resbr_load, lsq_load, rob_load,
           regfile_allocate, control_o, rvfi_o, count_o, stall_cnt_o
  );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester at or after ptr (wrapping)
// and returns the pointer one past the grant; the pointer holds without a grant.
module rr_arbiter #(
  parameter int N    = 2,
  parameter int PW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  input  logic          en,
  output logic [N-1:0]  grant,
  output logic [PW-1:0] next_ptr
);
  int   best;
  int   best_d;
  int   d;
  logic found;

  always_comb begin
    best     = 0;
    best_d   = N;
    d        = 0;
    found    = 1'b0;
    grant    = '0;
    next_ptr = ptr;
    for (int j = 0; j < N; j++) begin
      d = (j >= int'(ptr)) ? (j - int'(ptr)) : (j + N - int'(ptr));
      if (req[j] && (d < best_d)) begin
        best_d = d;
        best   = j;
        found  = 1'b1;
      end
    end
    if (en && found) begin
      for (int j = 0; j < N; j++) grant[j] = (best == j);
      next_ptr = PW'((best + 1) % N);
    end
  end
endmodule

// File: rtl/dispatch_queue.sv
// In-order instruction queue feeding ROB, reservation stations and LSQ, with
// one-cycle flush, occupancy output and a saturating stall counter.
module dispatch_queue import dispatch_queue_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int N_ALU = 2,
  parameter int N_CMP = 2,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input logic             clk,
  input logic             rst,
  dispatch_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int AP_W  = (N_ALU > 1) ? $clog2(N_ALU) : 1;
  localparam int CP_W  = (N_CMP > 1) ? $clog2(N_CMP) : 1;

  typedef struct packed {
    ctl_word  ctl;
    rvfi_word rvfi;
  } entry_t;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [31:0]      stall_cnt;
  logic [AP_W-1:0]  alu_ptr, alu_ptr_nxt;
  logic [CP_W-1:0]  cmp_ptr, cmp_ptr_nxt;
  ctl_word          head_ctl;
  logic             valid, issue, ack, dequeue;
  logic             is_br, is_mem, is_cmp, alu_en, cmp_en;

  assign head_ctl = mem[head].ctl;
  assign valid    = (count != '0);
  assign issue    = valid & ~bus.flush_ip & ~bus.rob_full;
  // Full test uses the registered count, so a full queue never accepts
  // in the same cycle it dispatches.
  assign ack      = bus.ld_iq & (count < CNT_W'(DEPTH)) & ~rst & ~bus.flush_ip;

  always_comb begin
    is_br  = (head_ctl.opcode == s_op_br);
    is_mem = (head_ctl.opcode == s_op_load) || (head_ctl.opcode == s_op_store);
    is_cmp = is_cmp_op(head_ctl);
  end

  assign alu_en = issue & ~is_br & ~is_mem & ~is_cmp;
  assign cmp_en = issue & is_cmp;

  rr_arbiter #(.N(N_ALU), .PW(AP_W)) u_alu_rr (
    .req(bus.alu_empty), .ptr(alu_ptr), .en(alu_en),
    .grant(bus.alu_load), .next_ptr(alu_ptr_nxt)
  );

  rr_arbiter #(.N(N_CMP), .PW(CP_W)) u_cmp_rr (
    .req(bus.cmp_empty), .ptr(cmp_ptr), .en(cmp_en),
    .grant(bus.cmp_load), .next_ptr(cmp_ptr_nxt)
  );

  assign bus.resbr_load       = issue & is_br & bus.resbr_empty;
  assign bus.lsq_load         = issue & is_mem & bus.lsq_empty;
  assign dequeue              = (|bus.alu_load) | (|bus.cmp_load) | bus.resbr_load | bus.lsq_load;
  assign bus.rob_load         = dequeue;
  assign bus.regfile_allocate = (|bus.alu_load) | (|bus.cmp_load) |
                                (bus.lsq_load & (head_ctl.opcode == s_op_load));
  assign bus.ack_o            = ack;
  assign bus.control_o        = valid ? head_ctl : CTL_INVALID;
  assign bus.rvfi_o           = mem[head].rvfi;
  assign bus.count_o          = count;
  assign bus.stall_cnt_o      = stall_cnt;

  always_ff @(posedge clk) begin
    if (ack) mem[tail] <= '{ctl: bus.ctl_i, rvfi: bus.rvfi_i};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      stall_cnt <= '0;
      alu_ptr   <= '0;
      cmp_ptr   <= '0;
    end else begin
      alu_ptr <= alu_ptr_nxt;
      cmp_ptr <= cmp_ptr_nxt;
      if (bus.flush_ip) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (ack)     tail <= tail + PTR_W'(1);
        if (dequeue) head <= head + PTR_W'(1);
        if (ack && !dequeue)      count <= count + CNT_W'(1);
        else if (!ack && dequeue) count <= count - CNT_W'(1);
        if (valid && !dequeue && (stall_cnt != 32'hFFFF_FFFF))
          stall_cnt <= stall_cnt + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_dispatch_queue.sv
// Directed test-plan steps followed by random traffic, all checked every cycle
// against a queue-based reference model.
module tb_dispatch_queue;
  import dispatch_queue_pkg::*;

  localparam int DEPTH = 8;
  localparam int N_ALU = 2;
  localparam int N_CMP = 2;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dispatch_queue_if #(.N_ALU(N_ALU), .N_CMP(N_CMP), .CNT_W(CNT_W)) bus ();

  dispatch_queue #(.DEPTH(DEPTH), .N_ALU(N_ALU), .N_CMP(N_CMP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  ctl_word         mq_ctl[$];
  rvfi_word        mq_rvfi[$];
  int              alu_rr, cmp_rr;
  longint unsigned stall;
  int              n_assert = 0;
  int              n_fail   = 0;

  rv32i_opcode ops [9] = '{s_op_lui, s_op_auipc, s_op_jal, s_op_jalr, s_op_br,
                           s_op_load, s_op_store, s_op_imm, s_op_reg};

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic ctl_word mk_ctl(rv32i_opcode op, arith_funct3 f3);
    ctl_word c;
    c.opcode = op;
    c.funct3 = f3;
    c.rd     = 5'($urandom);
    c.rs1    = 5'($urandom);
    c.rs2    = 5'($urandom);
    c.imm    = $urandom;
    return c;
  endfunction

  task automatic idle_in();
    bus.flush_ip    = 1'b0;
    bus.ld_iq       = 1'b0;
    bus.ctl_i       = CTL_INVALID;
    bus.rvfi_i      = '0;
    bus.alu_empty   = '0;
    bus.cmp_empty   = '0;
    bus.resbr_empty = 1'b0;
    bus.lsq_empty   = 1'b0;
    bus.rob_full    = 1'b0;
  endtask

  task automatic offer(ctl_word c);
    bus.ld_iq  = 1'b1;
    bus.ctl_i  = c;
    bus.rvfi_i = {$urandom, $urandom};
  endtask

  // One clock: predict outputs from the model, compare, clock, update model.
  task automatic step();
    logic             e_ack, e_br, e_lsq, e_rf, deq;
    logic [N_ALU-1:0] e_alu;
    logic [N_CMP-1:0] e_cmp;
    ctl_word          h;
    int               s, sz;
    #1;
    sz    = mq_ctl.size();
    e_ack = bus.ld_iq && (sz < DEPTH) && !rst && !bus.flush_ip;
    e_br = 1'b0; e_lsq = 1'b0; e_rf = 1'b0; e_alu = '0; e_cmp = '0;
    if (sz > 0 && !bus.flush_ip && !bus.rob_full) begin
      h = mq_ctl[0];
      if (h.opcode == s_op_br) e_br = bus.resbr_empty;
      else if (h.opcode == s_op_load || h.opcode == s_op_store) begin
        e_lsq = bus.lsq_empty;
        e_rf  = e_lsq && (h.opcode == s_op_load);
      end else if ((h.opcode == s_op_imm || h.opcode == s_op_reg) &&
                   (h.funct3 == f3_slt || h.funct3 == f3_sltu)) begin
        for (int k = 0; k < N_CMP; k++) begin
          s = (cmp_rr + k) % N_CMP;
          if (e_cmp == '0 && bus.cmp_empty[s]) e_cmp[s] = 1'b1;
        end
        e_rf = (e_cmp != '0);
      end else begin
        for (int k = 0; k < N_ALU; k++) begin
          s = (alu_rr + k) % N_ALU;
          if (e_alu == '0 && bus.alu_empty[s]) e_alu[s] = 1'b1;
        end
        e_rf = (e_alu != '0);
      end
    end
    deq = e_br || e_lsq || (e_alu != '0) || (e_cmp != '0);
    chk("ack_o", 64'(bus.ack_o), 64'(e_ack));
    chk("alu_load", 64'(bus.alu_load), 64'(e_alu));
    chk("cmp_load", 64'(bus.cmp_load), 64'(e_cmp));
    chk("resbr_load", 64'(bus.resbr_load), 64'(e_br));
    chk("lsq_load", 64'(bus.lsq_load), 64'(e_lsq));
    chk("rob_load", 64'(bus.rob_load), 64'(deq));
    chk("regfile_allocate", 64'(bus.regfile_allocate), 64'(e_rf));
    chk("count_o", 64'(bus.count_o), 64'(sz));
    chk("stall_cnt_o", 64'(bus.stall_cnt_o), stall);
    chk("control_o", 64'(bus.control_o), 64'((sz > 0) ? mq_ctl[0] : CTL_INVALID));
    if (sz > 0) chk("rvfi_o", bus.rvfi_o, mq_rvfi[0]);
    @(posedge clk);
    if (rst) begin
      mq_ctl.delete(); mq_rvfi.delete();
      alu_rr = 0; cmp_rr = 0; stall = 0;
    end else begin
      for (int j = 0; j < N_ALU; j++) if (e_alu[j]) alu_rr = (j + 1) % N_ALU;
      for (int j = 0; j < N_CMP; j++) if (e_cmp[j]) cmp_rr = (j + 1) % N_CMP;
      if (bus.flush_ip) begin
        mq_ctl.delete(); mq_rvfi.delete();
      end else begin
        if (deq) begin void'(mq_ctl.pop_front()); void'(mq_rvfi.pop_front()); end
        if (e_ack) begin mq_ctl.push_back(bus.ctl_i); mq_rvfi.push_back(bus.rvfi_i); end
        if (sz > 0 && !deq && stall != 64'hFFFF_FFFF) stall++;
      end
    end
    #1;
  endtask

  logic [N_ALU-1:0] seq_rr [4] = '{2'b01, 2'b10, 2'b01, 2'b10};

  initial begin
    alu_rr = 0; cmp_rr = 0; stall = 0;
    idle_in();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    #1;
    chk("reset_count", 64'(bus.count_o), 64'd0);
    chk("reset_control", 64'(bus.control_o), 64'(CTL_INVALID));
    chk("reset_ack", 64'(bus.ack_o), 64'd0);

    // Fill with adds while no ALU station is free, then keep offering.
    for (int i = 0; i < 8; i++) begin
      offer(mk_ctl(s_op_reg, f3_add));
      step();
    end
    offer(mk_ctl(s_op_reg, f3_add));
    #1;
    chk("full_count", 64'(bus.count_o), 64'd8);
    chk("full_ack", 64'(bus.ack_o), 64'd0);
    for (int i = 0; i < 3; i++) step();
    idle_in();

    bus.alu_empty = 2'b11;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alu_rr_seq", 64'(bus.alu_load), 64'(seq_rr[i]));
      step();
    end
    bus.alu_empty = 2'b10;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("alu_rr_fixed", 64'(bus.alu_load), 64'(2'b10));
      step();
    end

    // Compare op waits for a compare station even with ALUs free.
    idle_in();
    offer(mk_ctl(s_op_reg, f3_slt));
    step();
    idle_in();
    bus.alu_empty = 2'b11;
    step(); step();
    bus.cmp_empty = 2'b10;
    #1;
    chk("cmp_load", 64'(bus.cmp_load), 64'(2'b10));
    chk("cmp_rf", 64'(bus.regfile_allocate), 64'd1);
    step();

    idle_in();
    offer(mk_ctl(s_op_store, f3_add));
    step();
    idle_in();
    bus.lsq_empty = 1'b1;
    bus.rob_full  = 1'b1;
    step();
    bus.rob_full = 1'b0;
    #1;
    chk("store_lsq", 64'(bus.lsq_load), 64'd1);
    chk("store_rf", 64'(bus.regfile_allocate), 64'd0);
    chk("store_rob", 64'(bus.rob_load), 64'd1);
    step();

    // Flush with five words queued and a concurrent offer.
    idle_in();
    for (int i = 0; i < 5; i++) begin
      offer(mk_ctl(ops[$urandom_range(0, 8)], arith_funct3'($urandom_range(0, 7))));
      step();
    end
    bus.alu_empty = 2'b11; bus.cmp_empty = 2'b11;
    bus.lsq_empty = 1'b1; bus.resbr_empty = 1'b1;
    bus.flush_ip = 1'b1;
    #1;
    chk("flush_ack", 64'(bus.ack_o), 64'd0);
    chk("flush_rob", 64'(bus.rob_load), 64'd0);
    step();
    idle_in();
    #1;
    chk("post_flush_count", 64'(bus.count_o), 64'd0);
    chk("post_flush_op", 64'(bus.control_o.opcode), 64'(s_op_invalid));
    step();

    // Full queue with dispatch and offer in the same cycle.
    for (int i = 0; i < 8; i++) begin
      offer(mk_ctl(s_op_imm, f3_add));
      step();
    end
    bus.alu_empty = 2'b01;
    offer(mk_ctl(s_op_imm, f3_xor));
    #1;
    chk("full_deq_ack", 64'(bus.ack_o), 64'd0);
    step();
    #1;
    chk("full_deq_count", 64'(bus.count_o), 64'd7);
    chk("refill_ack", 64'(bus.ack_o), 64'd1);
    step();
    #1;
    chk("refill_count", 64'(bus.count_o), 64'd7);
    idle_in();
    bus.alu_empty = 2'b11;
    for (int i = 0; i < 8; i++) step();

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      rst             = ($urandom_range(0, 299) == 0);
      bus.flush_ip    = ($urandom_range(0, 39) == 0);
      bus.alu_empty   = N_ALU'($urandom);
      bus.cmp_empty   = N_CMP'($urandom);
      bus.resbr_empty = 1'($urandom);
      bus.lsq_empty   = 1'($urandom);
      bus.rob_full    = ($urandom_range(0, 5) == 0);
      bus.ld_iq       = ($urandom_range(0, 2) != 0);
      bus.ctl_i       = mk_ctl(ops[$urandom_range(0, 8)], arith_funct3'($urandom_range(0, 7)));
      bus.rvfi_i      = {$urandom, $urandom};
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
